dac_output_stage: RTL and testbench
===================================

Name: dac_output_stage

Overview:
Output end of the sample path. It accepts wide signed filter results over a valid/ready handshake, then rounds, scales and saturates each one to 12-bit signed. Results are buffered in a small FIFO and released to the 12-bit offset-binary DAC at a fixed sample cadence. It mirrors the ADC capture side, which sign-extends 12-bit samples up to WIDTH bits.

Parameters:
WIDTH, 36, bit width of signed input result (matches tap/accumulator width)
SHIFT, 15, arithmetic right shift (fractional bits) applied before saturation; legal range 1..WIDTH-12
DEPTH, 4, FIFO depth in samples; power of two, >=2
DIV, 8, clocks per DAC update tick; >=1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_data  in  WIDTH  signed filter result
in_valid  in  1  in_data valid
in_ready  out  1  stage can accept; = FIFO not full
underrun_clr  in  1  clears sticky underrun
dac_data  out  12  DAC code, offset binary
dac_wr  out  1  one-cycle pulse: dac_data just updated with a new sample
sat_flag  out  1  one-cycle pulse: accepted sample was clipped
underrun  out  1  sticky: tick occurred with FIFO empty
level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: dac_data=12'h800 (midscale), dac_wr=0, sat_flag=0, underrun=0, level=0, tick counter=0, in_ready=1 once FIFO is cleared.
- Reset mid-operation: FIFO contents are discarded and all reset values apply immediately (asynchronously).
- Accept: a transfer happens on a clk edge with in_valid&&in_ready. in_ready = (level<DEPTH), combinational from count only. There is no push while full, even if a pop occurs in the same cycle.
- Conversion (combinational on in_data, result written into the FIFO):
  - sum = sign-extended in_data (WIDTH+1 bits) + 2^(SHIFT-1)
  - q = sum >>> SHIFT (round half toward +inf)
  - q>2047 -> 2047; q<-2048 -> -2048; either case pulses sat_flag in the cycle after the accept edge.
  - The FIFO stores the 12-bit signed value.
- Tick counter: counts 0..DIV-1 and wraps. tick = (cnt==DIV-1). The first tick is on the DIV-th edge after reset release. With DIV=1, every cycle ticks.
- On a tick with level>0: pop the head, set dac_data = {~q[11], q[10:0]} (offset binary), and pulse dac_wr high for the following cycle.
- On a tick with level==0: dac_data holds its last value, dac_wr stays 0, underrun sets.
- underrun clears only on underrun_clr (asserted without a tick) or on rst. If set and clear coincide, set wins.
- Simultaneous push and pop (not full): level unchanged, and FIFO order is preserved.
- Latency: a sample accepted at edge N into an empty FIFO may appear on dac_data at the earliest on the tick edge N+1.
- Pointers: wrap modulo DEPTH. level is in the range 0..DEPTH.

Decomposition:
- Package dac_pkg holds:
  - DAC_BITS=12, DAC_MIDSCALE=12'h800, DAC_MAX=2047, DAC_MIN=-2048
  - function sat_round(value, shift), returning 12-bit signed plus a clip flag
  - function to_offset_binary
- Sub-module sample_fifo: a synchronous FIFO with parameters DEPTH and DATA_W=12. It has push/pop/full/empty/level ports and uses the same clk and rst.
- The top level holds the conversion, the tick counter and the output register.

Test Plan:
- Reset: assert rst mid-stream with FIFO level 3 -> dac_data=12'h800, level=0, in_ready=1, dac_wr=0, underrun=0 immediately.
- Scaling: SHIFT=15, in_data=100<<15 (3276800) -> on next tick dac_data=12'h864, dac_wr single pulse, sat_flag=0.
- Rounding: in_data=(5<<15)+16384 -> 12'h806 (+6). in_data=-(5<<15)-16384 -> 12'h7FB (-5).
- Saturation: in_data=3000<<15 -> 12'hFFF with sat_flag pulse. in_data=-(3000<<15) -> 12'h000 with sat_flag pulse.
- Backpressure/order: hold in_valid with 6 distinct values, DEPTH=4, DIV=8 -> in_ready drops at level 4, and all 6 values emerge in order, one per 8 clocks, with no loss.
- Underrun: stop input after 2 samples -> third tick leaves dac_data unchanged, dac_wr=0, underrun=1. underrun_clr pulse -> 0. Set and clear on the same edge -> stays 1.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and conversion helpers for the DAC output path.
// Samples are rounded, scaled and clipped to 12-bit signed, then re-encoded as offset binary.
package dac_pkg;

  localparam int DAC_BITS = 12;
  localparam logic [DAC_BITS-1:0] DAC_MIDSCALE = 12'h800;
  localparam int DAC_MAX = 2047;
  localparam int DAC_MIN = -2048;
  localparam int CALC_W = 64;

  typedef struct packed {
    logic signed [DAC_BITS-1:0] q;
    logic                       clip;
  } sat_result_t;

  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  function automatic sat_result_t sat_round(input logic signed [CALC_W-1:0] value,
                                            input int shift);
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] q;
    sat_result_t res;
    sum = value + (64'sd1 <<< (shift - 1));
    q   = sum >>> shift;
    if (q > signed'(CALC_W'(DAC_MAX))) begin
      res.q    = DAC_BITS'(DAC_MAX);
      res.clip = 1'b1;
    end else if (q < signed'(CALC_W'(DAC_MIN))) begin
      res.q    = DAC_BITS'(DAC_MIN);
      res.clip = 1'b1;
    end else begin
      res.q    = q[DAC_BITS-1:0];
      res.clip = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [DAC_BITS-1:0] to_offset_binary(input logic signed [DAC_BITS-1:0] q);
    return {~q[DAC_BITS-1], q[DAC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding converted 12-bit samples until the DAC tick consumes them.
// Push is refused while full and pop while empty, even if the other side is active.
module sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DAC_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_pushData,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_popData,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [LW-1:0]     r_level;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_popData = r_mem[r_rdPtr];
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
      unique case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dac_output_stage.sv
// Output end of the sample path: converts wide signed results to 12-bit codes,
// buffers them, and releases one to the offset-binary DAC every DIV clocks.
module dac_output_stage
  import dac_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4,
  parameter int DIV   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [WIDTH-1:0]    in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       underrun_clr,
  output logic [DAC_BITS-1:0]        dac_data,
  output logic                       dac_wr,
  output logic                       sat_flag,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic signed [CALC_W-1:0] w_ext;
  sat_result_t              w_conv;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_tick;
  logic                     w_full;
  logic                     w_empty;
  logic [DAC_BITS-1:0]      w_head;
  logic [CW-1:0]            r_cnt;
  logic [DAC_BITS-1:0]      r_dacData;
  logic                     r_dacWr;
  logic                     r_sat;
  logic                     r_underrun;

  assign w_ext    = CALC_W'(in_data);
  assign w_conv   = sat_round(w_ext, SHIFT);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_tick   = (r_cnt == CW'(DIV - 1));
  assign w_pop    = w_tick && !w_empty;

  sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DAC_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (w_conv.q),
    .i_pop      (w_pop),
    .o_popData  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  // A tick with an empty FIFO outranks a simultaneous underrun clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dacData  <= DAC_MIDSCALE;
      r_dacWr    <= 1'b0;
      r_sat      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_dacWr <= w_pop;
      r_sat   <= w_push && w_conv.clip;
      if (w_pop) r_dacData <= to_offset_binary(signed'(w_head));
      if (w_tick && w_empty) r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;
    end
  end

  assign dac_data = r_dacData;
  assign dac_wr   = r_dacWr;
  assign sat_flag = r_sat;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_dac_output_stage.sv
// Scoreboard bench: the driver queues the expected code and clip flag per accepted
// sample; monitors compare them whenever the DUT pulses dac_wr or a sample is accepted.
module tb_dac_output_stage;

  localparam int WIDTH = 36;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;
  localparam int DIV   = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    underrun_clr = 1'b0;
  logic [11:0]             dac_data;
  logic                    dac_wr;
  logic                    sat_flag;
  logic                    underrun;
  logic [2:0]              level;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] expQ[$];
  logic        satQ[$];
  logic        satPending = 1'b0;
  logic        satExp = 1'b0;
  int          phase = 0;
  int          cycle = 0;
  int          lastWrCycle = -1;
  logic        sawFull = 1'b0;
  logic [11:0] lastCode;

  dac_output_stage #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .DEPTH (DEPTH),
    .DIV   (DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .underrun_clr (underrun_clr),
    .dac_data     (dac_data),
    .dac_wr       (dac_wr),
    .sat_flag     (sat_flag),
    .underrun     (underrun),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Independent model of the tick phase: tick occurs on the edge where phase==DIV-1.
  always @(posedge clk or posedge rst) begin
    if (rst) phase <= 0;
    else phase <= (phase == DIV - 1) ? 0 : phase + 1;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Capture handshakes so the clip flag can be checked in the following cycle.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      satPending <= 1'b1;
      if (satQ.size() > 0) begin
        satExp <= satQ.pop_front();
      end else begin
        satExp <= 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL accept_unexpected: got accept, expected none");
      end
    end else begin
      satPending <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (satPending) checkOutput("sat_flag", 32'(sat_flag), 32'(satExp));
      else if (sat_flag) checkOutput("sat_flag_spurious", 32'(sat_flag), 32'd0);
      if (dac_wr) begin
        if (expQ.size() == 0) begin
          checkOutput("dac_wr_unexpected", 32'(dac_wr), 32'd0);
        end else begin
          checkOutput("dac_data", 32'(dac_data), 32'(expQ.pop_front()));
        end
        if (lastWrCycle >= 0) checkOutput("dac_wr_spacing", 32'((cycle - lastWrCycle) % DIV), 32'd0);
        lastWrCycle = cycle;
      end
      if (in_ready !== (level < 3'(DEPTH))) checkOutput("in_ready_vs_level", 32'(in_ready), 32'(level < 3'(DEPTH)));
      if (level == 3'(DEPTH) && !in_ready) sawFull = 1'b1;
    end
  end

  task automatic applyStimulus(input logic signed [WIDTH-1:0] d, input logic [11:0] code,
                               input logic sat);
    int waitCycles = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      expQ.push_back(code);
      satQ.push_back(sat);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic waitTickEdge();
    @(negedge clk);
    while (phase != DIV - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_dac_data", 32'(dac_data), 32'h800);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_dac_wr", 32'(dac_wr), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    checkOutput("reset_sat_flag", 32'(sat_flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scaling, rounding, saturation and the exact clip boundaries.
    applyStimulus(36'sd3276800, 12'h864, 1'b0);
    applyStimulus(36'sd180224, 12'h806, 1'b0);
    applyStimulus(-36'sd180224, 12'h7FB, 1'b0);
    applyStimulus(36'sd98304000, 12'hFFF, 1'b1);
    applyStimulus(-36'sd98304000, 12'h000, 1'b1);
    applyStimulus(36'sd67076096, 12'hFFF, 1'b0);
    applyStimulus(-36'sd67108864, 12'h000, 1'b0);
    applyStimulus(36'sd67092480, 12'hFFF, 1'b1);
    applyStimulus(-36'sd67125248, 12'h000, 1'b0);
    waitDrain();

    // Backpressure and ordering with six distinct values.
    sawFull = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(36'(7 * k) <<< SHIFT, 12'h800 + 12'(7 * k), 1'b0);
    end
    waitDrain();
    checkOutput("in_ready_low_at_full", 32'(sawFull), 32'd1);

    // Underrun: clear, feed two samples, then let the third tick find the FIFO empty.
    waitTickEdge();
    @(negedge clk);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);
    applyStimulus(36'sd655360, 12'h814, 1'b0);
    applyStimulus(-36'sd655360, 12'h7EC, 1'b0);
    waitTickEdge();
    checkOutput("tick1_dac_wr", 32'(dac_wr), 32'd1);
    checkOutput("tick1_dac_data", 32'(dac_data), 32'h814);
    waitTickEdge();
    checkOutput("tick2_dac_data", 32'(dac_data), 32'h7EC);
    checkOutput("tick2_underrun", 32'(underrun), 32'd0);
    lastCode = 12'h7EC;
    waitTickEdge();
    checkOutput("tick3_dac_wr", 32'(dac_wr), 32'd0);
    checkOutput("tick3_dac_data_hold", 32'(dac_data), 32'(lastCode));
    checkOutput("tick3_underrun", 32'(underrun), 32'd1);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    checkOutput("underrun_clr_pulse", 32'(underrun), 32'd0);
    @(negedge clk);
    while (phase != DIV - 1) @(negedge clk);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1 underrun_clr = 1'b0;
    checkOutput("underrun_set_wins", 32'(underrun), 32'd1);

    // Asynchronous reset with three samples buffered.
    waitTickEdge();
    applyStimulus(36'sd32768, 12'h801, 1'b0);
    applyStimulus(36'sd65536, 12'h802, 1'b0);
    applyStimulus(36'sd98304, 12'h803, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_level", 32'(level), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_dac_data", 32'(dac_data), 32'h800);
    checkOutput("midreset_level", 32'(level), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_dac_wr", 32'(dac_wr), 32'd0);
    checkOutput("midreset_underrun", 32'(underrun), 32'd0);
    expQ.delete();
    satQ.delete();
    lastWrCycle = -1;
    @(negedge clk);
    rst = 1'b0;

    // First tick after release lands on the DIV-th edge.
    applyStimulus(36'sd983040, 12'h81E, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("edge7_no_dac_wr", 32'(dac_wr), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("edge8_dac_wr", 32'(dac_wr), 32'd1);
    checkOutput("edge8_dac_data", 32'(dac_data), 32'h81E);
    waitDrain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
